ram_scan_ctrl: RTL
==================

# ram_scan_ctrl

Parametrised memory controller for the board-level RAM exercises. It owns a synchronous single-port RAM of 2^ADDR_W words of DATA_W bits and runs from the board clock, not a switch. Writes are triggered by edges on a request input, a clear sequence zeroes the whole array, and a scan mode walks the read address automatically. Its outputs (q, q_addr) drive the seven-segment decoders in the top level.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- SCAN_DIV, 50_000_000, clock cycles per scan step (≥1)

- clock  in  1  board clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- mode  in  1  0 = manual read at `address`; 1 = auto-scan
- wr_req  in  1  level input (switch/key); a rising edge requests one write
- clr_req  in  1  level input; a rising edge requests a full clear
- address  in  ADDR_W  manual read/write address
- data  in  DATA_W  write data
- q  out  DATA_W  registered read data
- q_addr  out  ADDR_W  address that q belongs to
- busy  out  1  high in WRITE and CLEAR
- wr_done  out  1  one-cycle pulse per completed write

## Operation
- Edge detect: wr_prev and clr_prev are registered copies of wr_req and clr_req.
  - Both reset to 1, so a level held high through reset causes no request.
  - wr_edge = wr_req & ~wr_prev; clr_edge likewise.
- States:
  - IDLE: manual mode.
  - SCAN: auto-scan mode.
  - WRITE: one cycle.
  - CLEAR: 2^ADDR_W cycles.
- IDLE/SCAN transitions, evaluated each cycle, in priority order:
  1. clr_edge → CLEAR; clr_ptr=0.
  2. wr_edge → WRITE; latch wa=address and wd=data.
  3. Otherwise IDLE if mode=0, SCAN if mode=1.
- WRITE: mem[wa]<=wd; wr_done=1 for this cycle. Next state is SCAN if mode=1, else IDLE.
- CLEAR:
  - mem[clr_ptr]<=0 and clr_ptr++ each cycle.
  - After writing address 2^ADDR_W-1, go to IDLE or SCAN per mode.
  - wr_edge and clr_edge arriving during CLEAR are discarded, not queued.
- Read address rd_addr: scan_addr in SCAN, address in IDLE.
  - Each IDLE/SCAN cycle: q<=mem[rd_addr] and q_addr<=rd_addr.
  - Read-first: a same-cycle write is not visible.
  - In WRITE and CLEAR, q and q_addr hold.
- Scan:
  - div counts 0..SCAN_DIV-1 while in SCAN.
  - When div reaches SCAN_DIV-1: div<=0 and scan_addr++.
  - scan_addr wraps 2^ADDR_W-1 → 0.
  - div and scan_addr hold outside SCAN; they do not reset on mode change.
- Reset mid-CLEAR aborts the clear. Words already cleared stay 0; the rest keep old contents. Reset never initialises the array.

## Timing
- Reset values:
  - q=0, q_addr=0, busy=0, wr_done=0.
  - state=IDLE, scan_addr=0, div=0, clr_ptr=0, wr_prev=clr_prev=1.
- Read latency: 1 cycle. An address sampled at edge k appears on q/q_addr after edge k.
- Write: wr_req low at edge k-1 and high at edge k gives:
  - WRITE during cycle k→k+1, with busy=1 and wr_done=1.
  - The array is updated at edge k+1.
  - The earliest read of the new value is on q after edge k+2.
- Back-to-back writes need wr_req low for at least one sampled edge between them.
- CLEAR takes exactly 2^ADDR_W cycles with busy=1, then busy=0.
- A scan step takes exactly SCAN_DIV cycles in SCAN. With SCAN_DIV=1, scan_addr increments every cycle.
- Simultaneous clr_edge and wr_edge: CLEAR wins and the write is lost.

## Test plan
Parameters for all scenarios: DATA_W=8, ADDR_W=5, SCAN_DIV=4.
- Reset with wr_req=clr_req=1 held, then release reset → no write and no clear; busy=0 and wr_done=0 for 10 cycles; q=0, q_addr=0.
- address=5'd3, data=8'hA7, one rising edge on wr_req → wr_done pulses exactly 1 cycle; q=8'hA7 and q_addr=3 two cycles after WRITE.
- Write 8'h11 at address 31, mode=1 → scan_addr sequence 0,1,…,31,0 with each value lasting 4 cycles; q=8'h11 exactly while q_addr=31.
- Fill addresses 0–31 with nonzero data, then a clr_req edge → busy high for exactly 32 cycles; every address then reads 8'h00. A wr_req edge during CLEAR causes no wr_done and no write.
- Assert reset at cycle 10 of a CLEAR → after reset, addresses 0–9 read 0 and addresses 10–31 keep their prior data.
- clr_req and wr_req rising on the same edge → CLEAR runs and no wr_done pulses.

Source files
------------

// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl: single-port RAM controller with edge-triggered writes,
// a full-array clear sequence and an auto-scanning read address.
//
// state | meaning
// IDLE  | manual read at `address`, waiting for write/clear requests
// SCAN  | read address walks the array, one step per SCAN_DIV cycles
// WRITE | one-cycle write of the latched word
// CLEAR | zeroes one word per cycle, 2^ADDR_W cycles in total
module ram_scan_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode,
  input  logic              wr_req,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] q_addr,
  output logic              busy,
  output logic              wr_done
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, CLEAR} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              wr_prev, clr_prev;
  logic              wr_edge, clr_edge;
  logic              rd_phase;
  logic [ADDR_W-1:0] wa, clr_ptr, scan_addr, rd_addr;
  logic [DATA_W-1:0] wd;
  logic [DIV_W-1:0]  div;

  assign wr_edge  = wr_req & ~wr_prev;
  assign clr_edge = clr_req & ~clr_prev;
  assign rd_phase = (state == IDLE) || (state == SCAN);
  assign rd_addr  = (state == SCAN) ? scan_addr : address;

  // Next-state decode; clear requests take priority over writes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    wr_done   = 1'b0;
    case (state)
      IDLE, SCAN: begin
        if (clr_edge)     state_nxt = CLEAR;
        else if (wr_edge) state_nxt = WRITE;
        else              state_nxt = mode ? SCAN : IDLE;
      end
      WRITE: begin
        busy      = 1'b1;
        wr_done   = 1'b1;
        state_nxt = mode ? SCAN : IDLE;
      end
      CLEAR: begin
        busy = 1'b1;
        if (clr_ptr == ADDR_LAST) state_nxt = mode ? SCAN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, request edge history, write latch, clear pointer, scan timer and read port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wr_prev   <= 1'b1;
      clr_prev  <= 1'b1;
      wa        <= '0;
      wd        <= '0;
      clr_ptr   <= '0;
      scan_addr <= '0;
      div       <= '0;
      q         <= '0;
      q_addr    <= '0;
    end else begin
      state    <= state_nxt;
      wr_prev  <= wr_req;
      clr_prev <= clr_req;

      if (rd_phase) begin
        q      <= mem[rd_addr];
        q_addr <= rd_addr;
        if (clr_edge) begin
          clr_ptr <= '0;
        end else if (wr_edge) begin
          wa <= address;
          wd <= data;
        end
      end

      if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;

      if (state == SCAN) begin
        if (div == DIV_LAST) begin
          div       <= '0;
          scan_addr <= scan_addr + 1'b1;
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

  // Array write port; a reset edge suppresses the write so an aborted clear stops cleanly.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == WRITE)      mem[wa]      <= wd;
      else if (state == CLEAR) mem[clr_ptr] <= '0;
    end
  end

endmodule
